// File: rtl/apb_requester.sv
// APB initiator: turns a single-outstanding command/response handshake into
// APB SETUP/ACCESS transfers, with a bounded wait on PREADY.
module apb_requester #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  // command channel
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  // response channel
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_TIMEOUT,
  output logic              BUSY,
  // APB requester port
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES-1; keep at least 1 bit
  // so the disabled configuration still elaborates cleanly.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Qualified helpers for the ACCESS-phase decisions.
  logic cmd_accept_c;
  logic timeout_hit_c;

  assign cmd_accept_c  = CMD_VALID && CMD_READY;
  assign timeout_hit_c = TO_EN && (wait_cnt == CNT_W'(TO_LAST));

  // Transfer sequencer: every output is a flop updated alongside the state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      CMD_READY   <= 1'b0;
      BUSY        <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state == IDLE && cmd_accept_c) begin
            PADDR     <= CMD_ADDR;
            PWRITE    <= CMD_WRITE;
            PWDATA    <= CMD_WRITE ? CMD_WDATA : '0;
            PSELx     <= 1'b1;
            PENABLE   <= 1'b0;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            state     <= SETUP;
          end else begin
            CMD_READY <= 1'b1;
            BUSY      <= 1'b0;
          end
        end

        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            // Completion takes priority over a timeout on the final cycle.
            RSP_RDATA   <= PWRITE ? '0 : PRDATA;
            RSP_ERR     <= PSLVERR;
            RSP_TIMEOUT <= 1'b0;
            RSP_VALID   <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else if (timeout_hit_c) begin
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b1;
            RSP_TIMEOUT <= 1'b1;
            RSP_VALID   <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else if (TO_EN) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            BUSY      <= 1'b0;
            CMD_READY <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // APB protocol sanity: enable only within a selected transfer.
  a_enable_needs_sel: assert property (
    @(posedge PCLK) disable iff (!PRESETn) PENABLE |-> PSELx
  );

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a small APB completer model.
module tb_apb_requester;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0;
  logic [31:0] CMD_WDATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        BUSY;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Completer model: PREADY rises after cur_dly wait cycles of ACCESS.
  int unsigned cur_dly    = 0;
  logic [31:0] cur_prdata = '0;
  logic        cur_slverr = 1'b0;
  int unsigned acc_cyc    = 0;
  logic [31:0] regs [16];

  assign PREADY  = PSELx && PENABLE && (acc_cyc >= cur_dly);
  assign PSLVERR = PREADY && cur_slverr;
  assign PRDATA  = cur_prdata;

  always @(posedge PCLK) begin
    if (PSELx && PENABLE && !PREADY) acc_cyc <= acc_cyc + 1;
    else acc_cyc <= 0;
    if (PSELx && PENABLE && PREADY && PWRITE && !PSLVERR) regs[PADDR[5:2]] <= PWDATA;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int unsigned dly;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int unsigned exp_acc;
  } vec_t;

  vec_t vecs [8];

  // Present a command once CMD_READY is seen; returns in the SETUP cycle.
  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] prdata, input int unsigned dly, input logic slverr,
                           input string tag);
    int n = 0;
    cur_dly = dly; cur_prdata = prdata; cur_slverr = slverr;
    while (!CMD_READY && n < 20) begin @(negedge PCLK); n++; end
    chk({tag, "_cmd_ready"}, 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdata;
    @(negedge PCLK);
    CMD_VALID = 1'b0; CMD_ADDR = 32'hFFFF_FFF0; CMD_WDATA = 32'hFFFF_FFFF; CMD_WRITE = ~wr;
    chk({tag, "_setup_sel"}, 32'(PSELx), 32'd1);
    chk({tag, "_setup_en"}, 32'(PENABLE), 32'd0);
    chk({tag, "_setup_addr"}, PADDR, addr);
    chk({tag, "_setup_write"}, 32'(PWRITE), 32'(wr));
    chk({tag, "_setup_wdata"}, PWDATA, wr ? wdata : 32'd0);
    chk({tag, "_setup_busy"}, 32'(BUSY), 32'd1);
  endtask

  // Count ACCESS cycles, checking address-phase stability, until RSP_VALID.
  task automatic wait_rsp(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input logic exp_to,
                          input int unsigned exp_acc, input string tag);
    int unsigned n = 0;
    logic done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (RSP_VALID) begin done = 1'b1; break; end
      if (PSELx && PENABLE) begin
        n++;
        chk({tag, "_acc_addr"}, PADDR, addr);
        chk({tag, "_acc_write"}, 32'(PWRITE), 32'(wr));
        chk({tag, "_acc_wdata"}, PWDATA, wr ? wdata : 32'd0);
      end
    end
    chk({tag, "_rsp_seen"}, 32'(done), 32'd1);
    chk({tag, "_acc_cycles"}, n, exp_acc);
    chk({tag, "_rdata"}, RSP_RDATA, exp_rdata);
    chk({tag, "_err"}, 32'(RSP_ERR), 32'(exp_err));
    chk({tag, "_timeout"}, 32'(RSP_TIMEOUT), 32'(exp_to));
    chk({tag, "_resp_sel"}, 32'({PSELx, PENABLE}), 32'd0);
    chk({tag, "_resp_cmd_ready"}, 32'(CMD_READY), 32'd0);
    chk({tag, "_resp_addr_hold"}, PADDR, addr);
  endtask

  task automatic ack(input logic [31:0] exp_rdata, input string tag);
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
    chk({tag, "_ack_valid"}, 32'(RSP_VALID), 32'd0);
    chk({tag, "_ack_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_ack_cmd_ready"}, 32'(CMD_READY), 32'd1);
    chk({tag, "_ack_rdata_kept"}, RSP_RDATA, exp_rdata);
  endtask

  task automatic run_vec(input int i);
    string tag = $sformatf("v%0d", i);
    start_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].prdata, vecs[i].dly,
              vecs[i].slverr, tag);
    wait_rsp(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
             vecs[i].exp_to, vecs[i].exp_acc, tag);
    ack(vecs[i].exp_rdata, tag);
  endtask

  initial begin
    //          wr    addr      wdata         prdata        dly  err   exp_rdata     e_err e_to acc
    vecs[0] = '{1'b1, 32'h08, 32'h0000_2A5A, 32'h1111_1111, 0,   1'b0, 32'h0,        1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h04, 32'h0,         32'hDEAD_BEEF, 3,   1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h10, 32'h0,         32'h1234_5678, 999, 1'b0, 32'h0,        1'b1, 1'b1, 16};
    vecs[3] = '{1'b0, 32'h0C, 32'h0,         32'hA5A5_0F0F, 1,   1'b0, 32'hA5A5_0F0F, 1'b0, 1'b0, 2};
    vecs[4] = '{1'b1, 32'h14, 32'h0000_0055, 32'h0,         0,   1'b1, 32'h0,        1'b1, 1'b0, 1};
    vecs[5] = '{1'b1, 32'h24, 32'hCAFE_F00D, 32'h0,         15,  1'b0, 32'h0,        1'b0, 1'b0, 16};
    vecs[6] = '{1'b0, 32'h30, 32'h0,         32'h0BAD_CAFE, 2,   1'b1, 32'h0BAD_CAFE, 1'b1, 1'b0, 3};
    vecs[7] = '{1'b1, 32'h28, 32'h0000_1234, 32'h0,         1,   1'b0, 32'h0,        1'b0, 1'b0, 2};

    for (int i = 0; i < 16; i++) regs[i] = '0;

    // Reset state.
    PRESETn = 1'b1;
    #1 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_apb_ctl", 32'({PSELx, PENABLE, PWRITE, BUSY}), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp_fields", 32'({RSP_ERR, RSP_TIMEOUT}) | RSP_RDATA, 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("post_rst_cmd_ready", 32'(CMD_READY), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(i);
    chk("bridge_config_reg", regs[2], 32'h0000_2A5A);
    chk("late_ready_write_reg", regs[9], 32'hCAFE_F00D);
    chk("slverr_write_not_stored", regs[5], 32'd0);

    // Response back-pressure with a pending command.
    start_cmd(1'b0, 32'h18, 32'h0, 32'h0BAD_F00D, 0, 1'b0, "hold");
    wait_rsp(1'b0, 32'h18, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, 1, "hold");
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h1C; CMD_WDATA = 32'h77;
    cur_prdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("hold_valid", 32'(RSP_VALID), 32'd1);
      chk("hold_rdata", RSP_RDATA, 32'h0BAD_F00D);
      chk("hold_flags", 32'({RSP_ERR, RSP_TIMEOUT}), 32'd0);
      chk("hold_cmd_ready", 32'(CMD_READY), 32'd0);
      chk("hold_no_sel", 32'(PSELx), 32'd0);
    end
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
    chk("hold_rel_valid", 32'(RSP_VALID), 32'd0);
    chk("hold_rel_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("hold_rel_no_sel", 32'(PSELx), 32'd0);
    @(negedge PCLK);
    CMD_VALID = 1'b0;
    chk("hold_next_sel", 32'({PSELx, PENABLE}), 32'b10);
    chk("hold_next_addr", PADDR, 32'h1C);
    chk("hold_next_wdata", PWDATA, 32'h77);
    wait_rsp(1'b1, 32'h1C, 32'h77, 32'h0, 1'b0, 1'b0, 1, "hold2");
    ack(32'h0, "hold2");
    chk("hold2_reg", regs[7], 32'h77);

    // Asynchronous reset in the middle of ACCESS.
    start_cmd(1'b0, 32'h20, 32'h0, 32'h5555_AAAA, 999, 1'b0, "arst");
    repeat (3) @(negedge PCLK);
    chk("arst_in_access", 32'({PSELx, PENABLE}), 32'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_sel_en", 32'({PSELx, PENABLE}), 32'd0);
    chk("arst_paddr", PADDR, 32'd0);
    chk("arst_busy", 32'(BUSY), 32'd0);
    @(negedge PCLK);
    chk("arst_no_rsp", 32'(RSP_VALID), 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("arst_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("arst_still_no_rsp", 32'(RSP_VALID), 32'd0);
    run_vec(7);
    chk("arst_write_reg", regs[10], 32'h0000_1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
